// File: rtl/l1_dcache_if.sv
// CPU-side (MEM stage) and memory-side (line-wide) buses of l1_dcache.
// On the CPU bus the pipeline is master; on the memory bus the cache is master.
interface l1_dcache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_byte_en;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_byte_en,
    input  cpu_rdata, cpu_stall
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_byte_en,
    output cpu_rdata, cpu_stall
  );
endinterface

interface l1_dcache_mem_if #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic                        mem_req;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [32*WORDS_PER_LINE-1:0] mem_wdata;
  logic                        mem_ready;
  logic [32*WORDS_PER_LINE-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a IDLE/WRITEBACK/REFILL miss FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module l1_dcache #(
  parameter int ADDR_W         = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic            clock,
  input  logic            reset,
  l1_dcache_cpu_if.slave  cpu_bus,
  l1_dcache_mem_if.master mem_bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_misses
`endif
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  state_e state_r;
  state_e state_nxt_s;

  logic [NUM_LINES-1:0]               valid_r;
  logic [NUM_LINES-1:0]               dirty_r;
  logic [TAG_W-1:0]                   tag_r  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][31:0]    data_r [NUM_LINES];

  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WSEL_W-1:0] wsel_s;
  logic              req_s;
  logic              hit_s;
  logic              store_hit_s;
  logic              wb_fire_s;
  logic              refill_fire_s;
  logic              unused_s;

  logic              stall_s;
  logic [31:0]       rdata_s;
  logic              mem_req_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;

  assign req_tag_s = cpu_bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign idx_s     = cpu_bus.cpu_addr[OFF_W +: IDX_W];
  assign wsel_s    = cpu_bus.cpu_addr[2 +: WSEL_W];
  assign unused_s  = ^cpu_bus.cpu_addr[1:0];

  assign req_s         = cpu_bus.cpu_rd | cpu_bus.cpu_wr;
  assign hit_s         = valid_r[idx_s] && (tag_r[idx_s] == req_tag_s);
  assign store_hit_s   = (state_r == IDLE) && cpu_bus.cpu_wr && hit_s;
  assign wb_fire_s     = (state_r == WRITEBACK) && mem_bus.mem_ready;
  assign refill_fire_s = (state_r == REFILL) && mem_bus.mem_ready;

  // Next-state and combinational outputs; hits answer and misses stall in the request cycle.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    rdata_s     = 32'd0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            rdata_s = data_r[idx_s][wsel_s];
          end else begin
            stall_s     = 1'b1;
            state_nxt_s = (valid_r[idx_s] && dirty_r[idx_s]) ? WRITEBACK : REFILL;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        stall_s    = 1'b1;
        mem_req_s  = 1'b1;
        mem_we_s   = 1'b1;
        mem_addr_s = {tag_r[idx_s], idx_s, {OFF_W{1'b0}}};
        if (mem_bus.mem_ready) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      REFILL: begin
        stall_s    = 1'b1;
        mem_req_s  = 1'b1;
        mem_addr_s = {req_tag_s, idx_s, {OFF_W{1'b0}}};
        if (mem_bus.mem_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign cpu_bus.cpu_stall = stall_s;
  assign cpu_bus.cpu_rdata = rdata_s;
  assign mem_bus.mem_req   = mem_req_s;
  assign mem_bus.mem_we    = mem_we_s;
  assign mem_bus.mem_addr  = mem_addr_s;
  assign mem_bus.mem_wdata = data_r[idx_s];

  // FSM state and per-line valid/dirty bits; the only state cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      valid_r <= {NUM_LINES{1'b0}};
      dirty_r <= {NUM_LINES{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (refill_fire_s) begin
        valid_r[idx_s] <= 1'b1;
        dirty_r[idx_s] <= 1'b0;
      end else if (wb_fire_s) begin
        dirty_r[idx_s] <= 1'b0;
      end else if (store_hit_s) begin
        dirty_r[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: whole-line refill, byte-lane merge on store hits (an empty mask merges nothing).
  always_ff @(posedge clock) begin
    if (!reset && refill_fire_s) begin
      data_r[idx_s] <= mem_bus.mem_rdata;
      tag_r[idx_s]  <= req_tag_s;
    end else if (!reset && store_hit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_bus.cpu_byte_en[b]) begin
          data_r[idx_s][wsel_s][8*b +: 8] <= cpu_bus.cpu_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits_r;
  logic [31:0] stat_misses_r;
  logic        refill_last_r;

  // Hit/miss counters; the replayed hit right after a refill belongs to the miss already counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits_r   <= 32'd0;
      stat_misses_r <= 32'd0;
      refill_last_r <= 1'b0;
    end else begin
      refill_last_r <= refill_fire_s;
      if ((state_r == IDLE) && req_s && hit_s && !refill_last_r) begin
        stat_hits_r <= stat_hits_r + 32'd1;
      end
      if ((state_r == IDLE) && req_s && !hit_s) begin
        stat_misses_r <= stat_misses_r + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_hits_r;
  assign stat_misses = stat_misses_r;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized self-checking bench for l1_dcache against a line-level cache/memory reference model.
// Counter checks are compiled in when DCACHE_STATS_EN is defined.
module tb_l1_dcache;

  localparam int NL  = 64;
  localparam int LW  = 128;

  logic clock;
  logic reset;

  l1_dcache_cpu_if #(.ADDR_W(32)) cpu_if ();
  l1_dcache_mem_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) mem_if ();

`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  l1_dcache #(
    .ADDR_W(32),
    .NUM_LINES(NL),
    .WORDS_PER_LINE(4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .cpu_bus(cpu_if.slave),
    .mem_bus(mem_if.master)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: cache contents as whole lines, backing store keyed by line address
  bit [NL-1:0]     m_valid;
  bit [NL-1:0]     m_dirty;
  logic [21:0]     m_tag  [NL];
  logic [LW-1:0]   m_line [NL];
  logic [LW-1:0]   backing [logic [31:0]];
  int              n_checks;
  int              n_fail;
  int unsigned     exp_hits;
  int unsigned     exp_misses;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [LW-1:0] get_line(input logic [31:0] la);
    if (!backing.exists(la)) backing[la] = rand_line();
    return backing[la];
  endfunction

  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    check_eq("stat_hits", stat_hits, exp_hits);
    check_eq("stat_misses", stat_misses, exp_misses);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    cpu_if.cpu_rd = 1'b0;
    cpu_if.cpu_wr = 1'b0;
    mem_if.mem_ready = 1'b0;
    @(posedge clock);
    #1;
    check_eq("rst_stall", cpu_if.cpu_stall, 1'b0);
    check_eq("rst_mem_req", mem_if.mem_req, 1'b0);
    check_eq("rst_mem_we", mem_if.mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_if.mem_addr, 32'd0);
    m_valid    = '0;
    m_dirty    = '0;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_stats();
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    cpu_if.cpu_rd = 1'b0;
    cpu_if.cpu_wr = 1'b0;
    mem_if.mem_ready = 1'($urandom_range(0, 1));
    mem_if.mem_rdata = rand_line();
    #1;
    check_eq("idle_stall", cpu_if.cpu_stall, 1'b0);
    check_eq("idle_mem_req", mem_if.mem_req, 1'b0);
    @(posedge clock);
  endtask

  // One CPU access held until it completes; memory answers after dly_wb/dly_rf wait cycles.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int dly_wb, input int dly_rf);
    logic [5:0]    idx;
    logic [1:0]    w;
    logic [21:0]   tg;
    logic [31:0]   line_a;
    logic [31:0]   vict_a;
    logic [LW-1:0] new_line;
    bit            hit;
    idx    = addr[9:4];
    w      = addr[3:2];
    tg     = addr[31:10];
    line_a = {addr[31:4], 4'h0};
    hit    = m_valid[idx] && (m_tag[idx] == tg);

    @(negedge clock);
    cpu_if.cpu_wr      = wr;
    cpu_if.cpu_rd      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu_if.cpu_addr    = addr;
    cpu_if.cpu_wdata   = wdata;
    cpu_if.cpu_byte_en = be;
    mem_if.mem_ready   = 1'($urandom_range(0, 1));
    mem_if.mem_rdata   = rand_line();
    #1;
    check_eq("req_stall", cpu_if.cpu_stall, !hit);

    if (!hit) begin
      exp_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        vict_a = {m_tag[idx], idx, 4'h0};
        for (int d = 0; d <= dly_wb; d++) begin
          @(negedge clock);
          mem_if.mem_ready = (d == dly_wb);
          mem_if.mem_rdata = rand_line();
          #1;
          check_eq("wb_stall", cpu_if.cpu_stall, 1'b1);
          check_eq("wb_req", mem_if.mem_req, 1'b1);
          check_eq("wb_we", mem_if.mem_we, 1'b1);
          check_eq("wb_addr", mem_if.mem_addr, vict_a);
          check_eq("wb_data", mem_if.mem_wdata, m_line[idx]);
        end
        backing[vict_a] = m_line[idx];
        m_dirty[idx] = 1'b0;
      end
      new_line = get_line(line_a);
      for (int d = 0; d <= dly_rf; d++) begin
        @(negedge clock);
        mem_if.mem_ready = (d == dly_rf);
        mem_if.mem_rdata = (d == dly_rf) ? new_line : rand_line();
        #1;
        check_eq("rf_stall", cpu_if.cpu_stall, 1'b1);
        check_eq("rf_req", mem_if.mem_req, 1'b1);
        check_eq("rf_we", mem_if.mem_we, 1'b0);
        check_eq("rf_addr", mem_if.mem_addr, line_a);
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_line[idx]  = new_line;
      @(negedge clock);
      mem_if.mem_ready = 1'b0;
      mem_if.mem_rdata = rand_line();
      #1;
      check_eq("replay_stall", cpu_if.cpu_stall, 1'b0);
    end else begin
      exp_hits++;
    end

    if (!wr) begin
      check_eq("rdata", cpu_if.cpu_rdata, m_line[idx][32*w +: 32]);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) m_line[idx][32*w + 8*b +: 8] = wdata[8*b +: 8];
      end
      m_dirty[idx] = 1'b1;
    end
    @(posedge clock);
    #1;
    check_stats();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [21:0] tsel;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    cpu_if.cpu_rd = 1'b0;
    cpu_if.cpu_wr = 1'b0;
    cpu_if.cpu_addr = 32'd0;
    cpu_if.cpu_wdata = 32'd0;
    cpu_if.cpu_byte_en = 4'd0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (2) @(posedge clock);
    do_reset();

    // clean miss, then hits on the rest of the line
    access(1'b0, 32'h100, 32'd0, 4'd0, 0, 0);
    access(1'b0, 32'h104, 32'd0, 4'd0, 0, 0);
    access(1'b0, 32'h108, 32'd0, 4'd0, 0, 0);
    access(1'b0, 32'h10C, 32'd0, 4'd0, 0, 0);
    // halfword store merge, then dirty conflict miss writes it back
    access(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011, 0, 0);
    access(1'b0, 32'h104, 32'd0, 4'd0, 0, 0);
    access(1'b0, 32'h500, 32'd0, 4'd0, 0, 0);
    // slow write-back: address/data must hold while mem_ready stays low
    access(1'b1, 32'h508, 32'h1234_5678, 4'b1111, 0, 0);
    access(1'b0, 32'h100, 32'd0, 4'd0, 5, 0);
    // empty byte mask still marks the line dirty
    access(1'b1, 32'h200, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    access(1'b0, 32'h600, 32'd0, 4'd0, 1, 2);
    idle_cycle();

    // reset while a refill is outstanding abandons it
    do_reset();
    @(negedge clock);
    cpu_if.cpu_rd = 1'b1;
    cpu_if.cpu_wr = 1'b0;
    cpu_if.cpu_addr = 32'h100;
    mem_if.mem_ready = 1'b0;
    @(negedge clock);
    #1;
    check_eq("t5_in_refill", mem_if.mem_req, 1'b1);
    do_reset();
    idle_cycle();
    access(1'b0, 32'h100, 32'd0, 4'd0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: tsel = 22'd0;
        1: tsel = 22'd1;
        2: tsel = 22'd2;
        default: tsel = 22'h3FFFFF;
      endcase
      a = {tsel, 3'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) idle_cycle();
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
